// File: rtl/puf_eval_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : puf_eval_ctrl
//  Purpose  : Arbiter-PUF evaluation controller. Launches races through the
//             selector chain, majority-votes repeated evaluations per bit,
//             steps the challenge with an LFSR and returns a response word
//             over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module puf_eval_ctrl #(
    parameter int CHAL_W = 4,
    parameter int RESP_W = 8,
    parameter int VOTES  = 5,
    parameter int SETTLE = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge_seed,
    output logic [CHAL_W-1:0] challenge,
    output logic              trigger,
    input  logic              line_a,
    input  logic              line_b,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_err,
    output logic              busy
);

    localparam int BIT_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int VOTE_W = $clog2(VOTES + 1);
    localparam int TIMER_W = $clog2(SETTLE + 1);

    localparam logic [BIT_W-1:0]   c_BIT_LAST   = BIT_W'(RESP_W - 1);
    localparam logic [VOTE_W-1:0]  c_VOTES      = VOTE_W'(VOTES);
    localparam logic [VOTE_W-1:0]  c_VOTES_HALF = VOTE_W'(VOTES / 2);
    localparam logic [TIMER_W-1:0] c_TIMER_LAST = TIMER_W'(SETTLE - 1);
    localparam logic [CHAL_W-1:0]  c_CHAL_ONE   = CHAL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRE  = 3'd1,
        S_WAIT  = 3'd2,
        S_RELAX = 3'd3,
        S_VOTE  = 3'd4,
        S_EMIT  = 3'd5
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [CHAL_W-1:0]   r_challenge,  w_challenge_nxt;
    logic                r_trigger,    w_trigger_nxt;
    logic [RESP_W-1:0]   r_resp_data,  w_resp_data_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic                r_resp_err,   w_resp_err_nxt;
    logic                r_busy,       w_busy_nxt;
    logic [BIT_W-1:0]    r_bit_idx,    w_bit_idx_nxt;
    logic [VOTE_W-1:0]   r_vote_cnt,   w_vote_cnt_nxt;
    logic [VOTE_W-1:0]   r_ones_cnt,   w_ones_cnt_nxt;
    logic [TIMER_W-1:0]  r_timer,      w_timer_nxt;

    logic                w_race_done;
    logic                w_race_bit;
    logic                w_voted;

    // State and datapath registers; reset aborts any word in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_challenge  <= '0;
            r_trigger    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_bit_idx    <= '0;
            r_vote_cnt   <= '0;
            r_ones_cnt   <= '0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_challenge  <= w_challenge_nxt;
            r_trigger    <= w_trigger_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_busy       <= w_busy_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_vote_cnt   <= w_vote_cnt_nxt;
            r_ones_cnt   <= w_ones_cnt_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // Next-state and next-value logic for the race / vote / emit sequence
    always_comb begin
        w_state_nxt      = r_state;
        w_challenge_nxt  = r_challenge;
        w_trigger_nxt    = r_trigger;
        w_resp_data_nxt  = r_resp_data;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_err_nxt   = r_resp_err;
        w_bit_idx_nxt    = r_bit_idx;
        w_vote_cnt_nxt   = r_vote_cnt;
        w_ones_cnt_nxt   = r_ones_cnt;
        w_timer_nxt      = r_timer;
        w_race_done      = 1'b0;
        w_race_bit       = 1'b0;
        w_voted          = (r_ones_cnt > c_VOTES_HALF);

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // an all-zero challenge would lock the LFSR, so substitute 1
                    w_challenge_nxt = (challenge_seed == '0) ? c_CHAL_ONE : challenge_seed;
                    w_bit_idx_nxt   = '0;
                    w_vote_cnt_nxt  = '0;
                    w_ones_cnt_nxt  = '0;
                    w_resp_err_nxt  = 1'b0;
                    w_resp_data_nxt = '0;
                    w_state_nxt     = S_FIRE;
                end
            end
            S_FIRE: begin
                w_trigger_nxt = 1'b1;
                w_timer_nxt   = '0;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (line_a && !line_b) begin
                    w_race_done = 1'b1;
                    w_race_bit  = 1'b1;
                end else if (line_b && !line_a) begin
                    w_race_done = 1'b1;
                end else if (line_a && line_b) begin
                    // tie: arbiter cannot resolve, record as 0 and flag it
                    w_race_done    = 1'b1;
                    w_resp_err_nxt = 1'b1;
                end else if (r_timer == c_TIMER_LAST) begin
                    w_race_done    = 1'b1;
                    w_resp_err_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
                if (w_race_done) begin
                    w_ones_cnt_nxt = r_ones_cnt + VOTE_W'(w_race_bit);
                    w_vote_cnt_nxt = r_vote_cnt + 1'b1;
                    w_trigger_nxt  = 1'b0;
                    w_state_nxt    = S_RELAX;
                end
            end
            S_RELAX: begin
                w_trigger_nxt = 1'b0;
                // both delay lines must drain before the next launch
                if (!line_a && !line_b) begin
                    w_state_nxt = (r_vote_cnt < c_VOTES) ? S_FIRE : S_VOTE;
                end
            end
            S_VOTE: begin
                w_resp_data_nxt = (r_resp_data << 1) | RESP_W'(w_voted);
                w_vote_cnt_nxt  = '0;
                w_ones_cnt_nxt  = '0;
                w_challenge_nxt = {r_challenge[CHAL_W-2:0],
                                   r_challenge[CHAL_W-1] ^ r_challenge[CHAL_W-2]};
                if (r_bit_idx == c_BIT_LAST) begin
                    w_resp_valid_nxt = 1'b1;
                    w_state_nxt      = S_EMIT;
                end else begin
                    w_bit_idx_nxt = r_bit_idx + 1'b1;
                    w_state_nxt   = S_FIRE;
                end
            end
            S_EMIT: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign challenge  = r_challenge;
    assign trigger    = r_trigger;
    assign resp_data  = r_resp_data;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_puf_eval_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_puf_eval_ctrl
//  Purpose  : Self-checking bench for puf_eval_ctrl. A line responder models
//             the delay chain from a per-race plan; expected words are queued
//             at stimulus time and compared by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_puf_eval_ctrl;

    localparam int CHAL_W = 4;
    localparam int RESP_W = 8;
    localparam int VOTES  = 5;
    localparam int SETTLE = 4;
    localparam int NRACE  = RESP_W * VOTES;

    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_A    = 2'd1;
    localparam logic [1:0] R_B    = 2'd2;
    localparam logic [1:0] R_TIE  = 2'd3;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic [CHAL_W-1:0] challenge_seed = '0;
    logic [CHAL_W-1:0] challenge;
    logic              trigger;
    logic              line_a = 1'b0;
    logic              line_b = 1'b0;
    logic [RESP_W-1:0] resp_data;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              resp_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [RESP_W:0]   exp_q[$];
    logic [1:0]        plan     [0:NRACE-1];
    logic [CHAL_W-1:0] chal_log [0:NRACE-1];
    int race_idx = 0;
    int trig_cnt = 0;
    int last_len = 0;
    int dly      = 1;

    puf_eval_ctrl #(
        .CHAL_W(CHAL_W), .RESP_W(RESP_W), .VOTES(VOTES), .SETTLE(SETTLE)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .start          (start),
        .challenge_seed (challenge_seed),
        .challenge      (challenge),
        .trigger        (trigger),
        .line_a         (line_a),
        .line_b         (line_b),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_err       (resp_err),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Delay-chain model: winner line rises dly cycles after trigger, loser one later
    initial begin
        forever begin
            @(negedge CLK);
            if (trigger === 1'b1) begin
                trig_cnt++;
                if (race_idx < NRACE) begin
                    if (trig_cnt == 1) chal_log[race_idx] = challenge;
                    if (trig_cnt == dly) begin
                        case (plan[race_idx])
                            R_A:     line_a = 1'b1;
                            R_B:     line_b = 1'b1;
                            R_TIE:   begin line_a = 1'b1; line_b = 1'b1; end
                            default: ;
                        endcase
                    end else if (trig_cnt == dly + 1) begin
                        case (plan[race_idx])
                            R_A:     line_b = 1'b1;
                            R_B:     line_a = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end else begin
                if (trig_cnt != 0) begin
                    last_len = trig_cnt;
                    race_idx++;
                end
                trig_cnt = 0;
                line_a   = 1'b0;
                line_b   = 1'b0;
            end
        end
    end

    // Monitor: every handshake must match the oldest queued expectation
    initial begin
        logic [RESP_W:0] e;
        forever begin
            @(negedge CLK);
            if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp actual=%0h required=none", resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", 32'(resp_data), 32'(e[RESP_W-1:0]));
                    check("resp_err",  32'(resp_err),  32'(e[RESP_W]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic fill_plan(input logic [1:0] code);
        for (int i = 0; i < NRACE; i++) plan[i] = code;
    endtask

    // Per-bit pattern: first nb races won by B, remainder by A
    task automatic set_bit_plan(input int b, input int nb);
        for (int v = 0; v < VOTES; v++) plan[b*VOTES + v] = (v < nb) ? R_B : R_A;
    endtask

    task automatic start_word(input logic [CHAL_W-1:0] seed);
        @(posedge CLK); #1;
        race_idx       = 0;
        challenge_seed = seed;
        start          = 1'b1;
        @(posedge CLK); #1;
        start          = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        check(name, 32'(busy), 32'd0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int nz;

        // reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_challenge",  32'(challenge),  32'd0);
        check("rst_trigger",    32'(trigger),    32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err",   32'(resp_err),   32'd0);
        check("rst_resp_data",  32'(resp_data),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        RST_N = 1'b1;

        // fixed winner, slow race, challenge sequence
        dly = 2;
        fill_plan(R_A);
        exp_q.push_back({1'b0, 8'hFF});
        start_word(4'b1001);
        wait_idle("fixed_done");
        check("chal_bit0",   32'(chal_log[0]),  32'h9);
        check("chal_bit0_v4",32'(chal_log[4]),  32'h9);
        check("chal_bit1",   32'(chal_log[5]),  32'h3);
        check("chal_bit2",   32'(chal_log[10]), 32'h6);
        check("chal_bit3",   32'(chal_log[15]), 32'hD);

        // majority, alternating per bit: 3A/2B -> 1, 2A/3B -> 0
        dly = 1;
        for (int b = 0; b < RESP_W; b++) set_bit_plan(b, (b % 2 == 0) ? 2 : 3);
        exp_q.push_back({1'b0, 8'hAA});
        start_word(4'b0110);
        wait_idle("alt_done");

        // majority for line_b on every bit
        for (int b = 0; b < RESP_W; b++) set_bit_plan(b, 3);
        exp_q.push_back({1'b0, 8'h00});
        start_word(4'b1111);
        wait_idle("allb_done");

        // timeout: lines never rise
        fill_plan(R_NONE);
        exp_q.push_back({1'b1, 8'h00});
        start_word(4'b0010);
        wait_idle("timeout_done");
        check("timeout_wait_len", 32'(last_len), 32'(SETTLE));

        // single tie outvoted
        fill_plan(R_A);
        plan[7] = R_TIE;
        exp_q.push_back({1'b1, 8'hFF});
        start_word(4'b1010);
        wait_idle("tie_done");

        // zero seed substitution, challenge never zero
        fill_plan(R_A);
        exp_q.push_back({1'b0, 8'hFF});
        start_word(4'b0000);
        wait_idle("zseed_done");
        check("zseed_load", 32'(chal_log[0]), 32'h1);
        nz = 0;
        for (int i = 0; i < NRACE; i++) if (chal_log[i] != '0) nz++;
        check("zseed_nonzero", 32'(nz), 32'(NRACE));

        // backpressure with dropped start pulses
        resp_ready = 1'b0;
        exp_q.push_back({1'b0, 8'hFF});
        start_word(4'b0101);
        n = 0;
        while (resp_valid !== 1'b1 && n < 3000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("bp_valid_seen", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge CLK); #1;
            check("bp_valid_hold", 32'(resp_valid), 32'd1);
            check("bp_data_hold",  32'(resp_data),  32'hFF);
        end
        resp_ready = 1'b1;
        start      = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        check("bp_valid_drop", 32'(resp_valid), 32'd0);
        check("bp_busy_drop",  32'(busy),       32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("bp_start_dropped", 32'(busy), 32'd0);
        check("bp_one_transfer",  32'(exp_q.size()), 32'd0);

        // asynchronous reset during WAIT
        fill_plan(R_NONE);
        start_word(4'b0011);
        n = 0;
        while (trigger !== 1'b1 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("rstw_trigger_seen", 32'(trigger), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("rstw_trigger", 32'(trigger),    32'd0);
        check("rstw_busy",    32'(busy),       32'd0);
        check("rstw_valid",   32'(resp_valid), 32'd0);
        check("rstw_chal",    32'(challenge),  32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("rstw_stays_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
- Drives the trigger edge and the challenge bits into the arbiter-PUF selector chain.
- Captures the race at the chain's two final delay-line outputs with an arbiter, repeating each evaluation VOTES times.
- Majority-votes each response bit and assembles RESP_W bits into a response word, stepping the challenge through an LFSR between bits.
- Hands the word downstream over a valid/ready handshake.

Parameters:
CHAL_W, 4, challenge width (number of selector stages)
RESP_W, 8, response bits per word
VOTES, 5, evaluations per response bit; must be odd and at least 1
SETTLE, 4, max cycles to wait for a race winner after trigger rises

Ports:
CLK  input  1  clock
RST_N  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a word; ignored while busy
challenge_seed  input  CHAL_W  initial challenge, sampled on accepted start
challenge  output  CHAL_W  challenge bits driven to the selector stages
trigger  output  1  race-launch signal fed to both line inputs of stage 0
line_a  input  1  final delay-line output, path 0
line_b  input  1  final delay-line output, path 1
resp_data  output  RESP_W  assembled response, first bit in the MSB
resp_valid  output  1  resp_data valid
resp_ready  input  1  downstream accepts
resp_err  output  1  qualified by resp_valid: a timeout or tie occurred in this word
busy  output  1  high in every state except IDLE

Behaviour:
Reset and outputs:
- Reset is asynchronous and active-low; one clock, CLK.
- While RST_N is low, all registers clear: state=IDLE, challenge=0, trigger=0, resp_data=0, resp_valid=0, resp_err=0, busy=0, and all counters cleared.
- Reset asserted mid-word aborts the word immediately. No partial response is ever emitted.
- All outputs are registered.

States:
- IDLE: on start=1, load challenge=challenge_seed (0 is replaced by 1). Clear bit_idx, vote_cnt, ones_cnt, resp_err and resp_data. Go to FIRE.
- FIRE: set trigger=1, clear timer, go to WAIT.
- WAIT: each cycle, inspect line_a and line_b.
  - line_a=1, line_b=0: sample bit 1.
  - line_b=1, line_a=0: sample bit 0.
  - Both 1 in the same cycle (tie): sample bit 0 and set resp_err.
  - Neither high and timer==SETTLE-1: timeout; sample bit 0 and set resp_err.
  - Otherwise increment timer and stay in WAIT.
  - On any sample: ones_cnt += bit, vote_cnt += 1, go to RELAX.
  - First trigger high cycle to the earliest possible sample: 1 cycle.
- RELAX: set trigger=0. Stay until line_a==0 and line_b==0.
  - Then, if vote_cnt<VOTES, go to FIRE.
  - Otherwise go to VOTE.
- VOTE: compute bit = (ones_cnt > VOTES/2) and shift it into resp_data LSB (left shift).
  - Clear vote_cnt and ones_cnt.
  - Advance the LFSR: challenge <= {challenge[CHAL_W-2:0], challenge[CHAL_W-1]^challenge[CHAL_W-2]}.
  - If bit_idx==RESP_W-1, go to EMIT; otherwise increment bit_idx and go to FIRE.
- EMIT: resp_valid=1. Hold resp_data and resp_err stable until resp_ready=1.
  - The transfer occurs on the cycle where resp_valid=1 and resp_ready=1.
  - On that edge, resp_valid goes to 0 and the state returns to IDLE.
  - resp_ready held high before EMIT does not shorten EMIT; it lasts at least one cycle.

Boundary rules:
- start while busy is dropped. start in the same cycle as the EMIT handshake is also dropped.
- The challenge never takes the value 0: the seed substitution guarantees this and the LFSR preserves it.
- The challenge is stable from FIRE through RELAX; it changes only in VOTE.
- VOTES=1: the voted bit equals the single sample.

Word length:
- Cycles from start to resp_valid are at least RESP_W*(VOTES*3+1)+1 when each race resolves in 1 cycle and the lines relax in 1 cycle.

Test Plan:
- Fixed winner: bench drives line_a high 2 cycles after trigger rises, line_b 1 cycle later, both low when trigger drops. Seed 4'b1001 -> resp_data=8'hFF, resp_err=0, and the challenge sequence starts 1001, 0011, 0110, 1101.
- Majority: per bit, line_b wins 2 of 5 races and line_a wins 3 -> each bit is 1. Swapping to 3 wins for line_b gives 0. Alternating per bit gives resp_data=8'hAA.
- Timeout: lines never rise -> each WAIT lasts SETTLE=4 cycles, resp_data=8'h00, resp_err=1.
- Tie: line_a and line_b rise in the same cycle on one race only, line_a wins all others -> resp_data=8'hFF (the tie is outvoted), resp_err=1.
- Backpressure and reset: hold resp_ready=0 for 10 cycles in EMIT -> resp_valid and resp_data stay stable, and a start pulse is ignored. Then raise resp_ready -> one transfer and busy drops next cycle. Separately, pull RST_N low mid-WAIT -> trigger=0, busy=0 and resp_valid=0 immediately.
- Zero seed: challenge_seed=0 -> challenge loads as 4'b0001 and never reaches 0 over the word.
